samm_stream: RTL and testbench

Streaming, handshaked successor to the fixed-size systolic matrix multiplier. It computes P = A(R×K) × B(K×C) on an R×C output-stationary array of signed N-bit MACs. The reduction depth K is variable per tile and marked by `In_Last`, and an accumulate mode adds one tile's products onto the previous results. Results stream out one row per beat under valid/ready backpressure. The block sits between the operand fetch stage and the result writer in the accelerator datapath.

---
 rtl/samm_stream_pkg.sv | 29 ++
 rtl/samm_stream_if.sv | 33 +++
 rtl/samm_stream_pe.sv | 50 +++++
 rtl/samm_stream.sv | 211 +++++++++++++++++++++
 tb/tb_samm_stream.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/samm_stream_pkg.sv
// Shared types, default parameters and a width helper for the streaming
// systolic matrix multiplier.
package samm_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

    localparam int DEF_N     = 8;
    localparam int DEF_R     = 4;
    localparam int DEF_C     = 4;
    localparam int DEF_ACC_W = 32;

    // Bits needed to index 0..value-1, never less than one.
    function automatic int samm_clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/samm_stream_if.sv
// Operand-in / result-out handshake bundle; the multiplier is the slave,
// the fetch stage and result writer together form the master.
interface samm_stream_if import samm_stream_pkg::*; #(
    parameter int N     = DEF_N,
    parameter int R     = DEF_R,
    parameter int C     = DEF_C,
    parameter int ACC_W = DEF_ACC_W
);
    localparam int ROW_W = samm_clog2(R);

    logic                 In_Dv;
    logic                 In_Rdy;
    logic                 In_Last;
    logic                 Acc_En;
    logic [R*N-1:0]       In_A;
    logic [C*N-1:0]       In_B;
    logic                 Out_Dv;
    logic                 Out_Rdy;
    logic [C*ACC_W-1:0]   Out_Data;
    logic [ROW_W-1:0]     Out_Row;
    logic                 Out_Last;

    modport master (
        output In_Dv, In_Last, Acc_En, In_A, In_B, Out_Rdy,
        input  In_Rdy, Out_Dv, Out_Data, Out_Row, Out_Last
    );

    modport slave (
        input  In_Dv, In_Last, Acc_En, In_A, In_B, Out_Rdy,
        output In_Rdy, Out_Dv, Out_Data, Out_Row, Out_Last
    );

endinterface

// File: rtl/samm_stream_pe.sv
// One output-stationary MAC cell: forwards A right and B down by one cycle
// and accumulates their signed product with wrap-around.
module samm_stream_pe import samm_stream_pkg::*; #(
    parameter int N     = DEF_N,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    clr,
    input  logic signed [N-1:0]     a_in,
    input  logic signed [N-1:0]     b_in,
    output logic signed [N-1:0]     a_out,
    output logic signed [N-1:0]     b_out,
    output logic signed [ACC_W-1:0] acc
);
    logic signed [N-1:0]     a_q, a_d;
    logic signed [N-1:0]     b_q, b_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [2*N-1:0]   prod_s;

    // Clear wins over the product so a fresh tile starts from zero.
    always_comb begin
        a_d    = a_in;
        b_d    = b_in;
        prod_s = a_in * b_in;
        if (clr) begin
            acc_d = '0;
        end else begin
            acc_d = acc_q + ACC_W'(prod_s);
        end
    end

    // Pass-through operand registers and accumulator.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/samm_stream.sv
// Streaming R x C output-stationary matrix multiplier: skewed operand entry,
// PE array, drain timer and row-by-row result streaming.
module samm_stream import samm_stream_pkg::*; #(
    parameter int N     = DEF_N,
    parameter int R     = DEF_R,
    parameter int C     = DEF_C,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic         Clk,
    input  logic         Rst_n,
    samm_stream_if.slave bus,
    output logic         Busy
);
    localparam int ROW_W = samm_clog2(R);
    localparam int CNT_W = samm_clog2(R + C);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(R + C - 2);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(R - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             in_rdy_s, out_dv_s, accept_s, clr_s;

    logic signed [N-1:0]     a_w   [R][C];
    logic signed [N-1:0]     b_w   [R][C];
    logic signed [ACC_W-1:0] acc_w [R][C];

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.In_Dv) begin
                    state_d = bus.In_Last ? DRAIN : LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (bus.In_Dv && bus.In_Last) begin
                    state_d = DRAIN;
                end else begin
                    state_d = LOAD;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = OUT;
                end else begin
                    state_d = DRAIN;
                end
            end
            OUT: begin
                if (bus.Out_Rdy && (row_q == ROW_LAST)) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state only; data is zero when not valid.
    always_comb begin
        in_rdy_s = 1'b0;
        out_dv_s = 1'b0;
        Busy     = 1'b1;
        case (state_q)
            IDLE: begin
                in_rdy_s = 1'b1;
                Busy     = 1'b0;
            end
            LOAD:    in_rdy_s = 1'b1;
            DRAIN:   in_rdy_s = 1'b0;
            OUT:     out_dv_s = 1'b1;
            default: Busy     = 1'b0;
        endcase
        bus.In_Rdy = in_rdy_s;
        bus.Out_Dv = out_dv_s;
        if (out_dv_s) begin
            for (int c = 0; c < C; c++) begin
                bus.Out_Data[c*ACC_W +: ACC_W] = acc_w[row_q][c];
            end
            bus.Out_Row  = row_q;
            bus.Out_Last = (row_q == ROW_LAST);
        end else begin
            bus.Out_Data = '0;
            bus.Out_Row  = '0;
            bus.Out_Last = 1'b0;
        end
    end

    // Handshake qualifiers, drain timer and output row pointer.
    always_comb begin
        accept_s = in_rdy_s & bus.In_Dv;
        clr_s    = (state_q == IDLE) & bus.In_Dv & ~bus.Acc_En;
        if (state_q == DRAIN) begin
            drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end else begin
            drain_cnt_d = '0;
        end
        if (out_dv_s && bus.Out_Rdy) begin
            if (row_q == ROW_LAST) begin
                row_d = '0;
            end else begin
                row_d = row_q + ROW_W'(1);
            end
        end else begin
            row_d = row_q;
        end
    end

    // Counter registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            drain_cnt_q <= '0;
            row_q       <= '0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
            row_q       <= row_d;
        end
    end

    // Row r of A enters r cycles after the entry stage; idle cycles push zeros.
    for (genvar r = 0; r < R; r++) begin : g_askew
        logic signed [N-1:0] dly_q [r+1];
        logic signed [N-1:0] dly_d [r+1];

        always_comb begin
            dly_d[0] = accept_s ? bus.In_A[r*N +: N] : '0;
            for (int j = 1; j <= r; j++) begin
                dly_d[j] = dly_q[j-1];
            end
        end

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                dly_q <= '{default: '0};
            end else begin
                dly_q <= dly_d;
            end
        end

        assign a_w[r][0] = dly_q[r];
    end

    // Column c of B enters c cycles after the entry stage.
    for (genvar c = 0; c < C; c++) begin : g_bskew
        logic signed [N-1:0] dly_q [c+1];
        logic signed [N-1:0] dly_d [c+1];

        always_comb begin
            dly_d[0] = accept_s ? bus.In_B[c*N +: N] : '0;
            for (int j = 1; j <= c; j++) begin
                dly_d[j] = dly_q[j-1];
            end
        end

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                dly_q <= '{default: '0};
            end else begin
                dly_q <= dly_d;
            end
        end

        assign b_w[0][c] = dly_q[c];
    end

    for (genvar r = 0; r < R; r++) begin : g_row
        for (genvar c = 0; c < C; c++) begin : g_col
            logic signed [N-1:0] a_nxt_s, b_nxt_s;

            samm_stream_pe #(.N(N), .ACC_W(ACC_W)) u_pe (
                .Clk   (Clk),
                .Rst_n (Rst_n),
                .clr   (clr_s),
                .a_in  (a_w[r][c]),
                .b_in  (b_w[r][c]),
                .a_out (a_nxt_s),
                .b_out (b_nxt_s),
                .acc   (acc_w[r][c])
            );

            // Edge cells have no neighbour to feed.
            if (c < C - 1) begin : g_a_fwd
                assign a_w[r][c+1] = a_nxt_s;
            end else begin : g_a_edge
                logic unused_a_s;
                assign unused_a_s = ^a_nxt_s;
            end
            if (r < R - 1) begin : g_b_fwd
                assign b_w[r+1][c] = b_nxt_s;
            end else begin : g_b_edge
                logic unused_b_s;
                assign unused_b_s = ^b_nxt_s;
            end
        end
    end

endmodule

// File: tb/tb_samm_stream.sv
// Bench for samm_stream: a 32-bit and a 16-bit accumulator instance share
// stimulus and are checked against a plain matrix-product reference model.
module tb_samm_stream;
    import samm_stream_pkg::*;

    localparam int N       = 8;
    localparam int R       = 4;
    localparam int C       = 4;
    localparam int ACC_W   = 32;
    localparam int ACC_W16 = 16;
    localparam int ROW_W   = samm_clog2(R);
    localparam int KMAX    = 8;

    logic Clk = 1'b0;
    logic Rst_n;
    logic busy32, busy16;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_e;

    logic signed [N-1:0]  a_m   [R][KMAX];
    logic signed [N-1:0]  b_m   [KMAX][C];
    logic signed [63:0]   ref_p [R][C];
    logic [C*ACC_W-1:0]   cap32_last;
    logic [C*ACC_W16-1:0] cap16_row0;

    samm_stream_if #(.N(N), .R(R), .C(C), .ACC_W(ACC_W))   bus   ();
    samm_stream_if #(.N(N), .R(R), .C(C), .ACC_W(ACC_W16)) bus16 ();

    assign bus16.In_Dv   = bus.In_Dv;
    assign bus16.In_Last = bus.In_Last;
    assign bus16.Acc_En  = bus.Acc_En;
    assign bus16.In_A    = bus.In_A;
    assign bus16.In_B    = bus.In_B;
    assign bus16.Out_Rdy = bus.Out_Rdy;

    samm_stream #(.N(N), .R(R), .C(C), .ACC_W(ACC_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .bus(bus), .Busy(busy32)
    );
    samm_stream #(.N(N), .R(R), .C(C), .ACC_W(ACC_W16)) dut16 (
        .Clk(Clk), .Rst_n(Rst_n), .bus(bus16), .Busy(busy16)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic fill_random(input int k_len);
        for (int k = 0; k < k_len; k++) begin
            for (int r = 0; r < R; r++) a_m[r][k] = N'($urandom);
            for (int c = 0; c < C; c++) b_m[k][c] = N'($urandom);
        end
    endtask

    // Streams K beats of a_m/b_m and updates the reference product.
    task automatic send_tile(input int k_len, input bit acc, input bit gaps);
        int g;
        if (!acc) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) ref_p[r][c] = 64'sd0;
        end
        for (int k = 0; k < k_len; k++)
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    ref_p[r][c] = ref_p[r][c] + 64'(a_m[r][k]) * 64'(b_m[k][c]);
        for (int k = 0; k < k_len; k++) begin
            g = gaps ? $urandom_range(0, 2) : 0;
            repeat (g) begin
                bus.In_Dv   = 1'b0;
                bus.In_A    = $urandom;
                bus.In_B    = $urandom;
                bus.In_Last = 1'($urandom_range(0, 1));
                @(negedge Clk);
            end
            bus.In_Dv = 1'b1;
            for (int r = 0; r < R; r++) bus.In_A[r*N +: N] = a_m[r][k];
            for (int c = 0; c < C; c++) bus.In_B[c*N +: N] = b_m[k][c];
            bus.In_Last = (k == k_len - 1);
            bus.Acc_En  = (k == 0) ? acc : 1'($urandom_range(0, 1));
            n_cmp++;
            if (bus.In_Rdy !== 1'b1) begin
                n_err++;
                $display("FAIL in_rdy_load beat=%0d got=%b exp=1", k, bus.In_Rdy);
            end
            @(negedge Clk);
        end
        bus.In_Dv   = 1'b0;
        bus.In_Last = 1'b0;
        last_e      = cyc;
    endtask

    // Collects R rows from both instances, optionally stalling one row.
    task automatic recv_tile(input int stall_row, input int stall_len);
        int guard;
        logic [C*ACC_W-1:0]   exp32;
        logic [C*ACC_W16-1:0] exp16;
        bus.Out_Rdy = 1'b1;
        n_cmp++;
        if (bus.In_Rdy !== 1'b0 || busy32 !== 1'b1 || busy16 !== 1'b1) begin
            n_err++;
            $display("FAIL drain_state in_rdy=%b busy=%b/%b exp in_rdy=0 busy=1", bus.In_Rdy, busy32, busy16);
        end
        guard = 0;
        while (bus.Out_Dv !== 1'b1 && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        n_cmp++;
        if (cyc - last_e != R + C - 1 || bus16.Out_Dv !== 1'b1) begin
            n_err++;
            $display("FAIL out_latency got=%0d exp=%0d dv16=%b", cyc - last_e, R + C - 1, bus16.Out_Dv);
        end
        if (guard >= 100) return;
        for (int row = 0; row < R; row++) begin
            for (int c = 0; c < C; c++) begin
                exp32[c*ACC_W +: ACC_W]     = ref_p[row][c][ACC_W-1:0];
                exp16[c*ACC_W16 +: ACC_W16] = ref_p[row][c][ACC_W16-1:0];
            end
            if (row == 0) cap16_row0 = bus16.Out_Data;
            if (row == R - 1) cap32_last = bus.Out_Data;
            n_cmp++;
            if (bus.Out_Dv !== 1'b1 || bus.Out_Row !== ROW_W'(row) ||
                bus.Out_Last !== (row == R - 1) || bus.Out_Data !== exp32) begin
                n_err++;
                $display("FAIL row32 row=%0d got row=%0d last=%b data=%h exp data=%h",
                         row, bus.Out_Row, bus.Out_Last, bus.Out_Data, exp32);
            end
            n_cmp++;
            if (bus16.Out_Dv !== 1'b1 || bus16.Out_Row !== ROW_W'(row) ||
                bus16.Out_Last !== (row == R - 1) || bus16.Out_Data !== exp16) begin
                n_err++;
                $display("FAIL row16 row=%0d got row=%0d last=%b data=%h exp data=%h",
                         row, bus16.Out_Row, bus16.Out_Last, bus16.Out_Data, exp16);
            end
            if (row == stall_row) begin
                bus.Out_Rdy = 1'b0;
                repeat (stall_len) begin
                    @(negedge Clk);
                    n_cmp++;
                    if (bus.Out_Dv !== 1'b1 || bus.Out_Row !== ROW_W'(row) ||
                        bus.Out_Data !== exp32 || bus.In_Rdy !== 1'b0) begin
                        n_err++;
                        $display("FAIL stall_hold row=%0d got row=%0d data=%h in_rdy=%b exp data=%h in_rdy=0",
                                 row, bus.Out_Row, bus.Out_Data, bus.In_Rdy, exp32);
                    end
                end
                bus.Out_Rdy = 1'b1;
            end
            @(negedge Clk);
        end
        n_cmp++;
        if (bus.Out_Dv !== 1'b0 || bus.In_Rdy !== 1'b1 || busy32 !== 1'b0 || busy16 !== 1'b0 ||
            bus.Out_Data !== '0 || bus.Out_Row !== '0 || bus.Out_Last !== 1'b0) begin
            n_err++;
            $display("FAIL post_tile got dv=%b rdy=%b busy=%b data=%h row=%0d last=%b exp idle zeros",
                     bus.Out_Dv, bus.In_Rdy, busy32, bus.Out_Data, bus.Out_Row, bus.Out_Last);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        for (int pass = 0; pass < 2; pass++) begin
            n_cmp++;
            if (bus.In_Rdy !== 1'b1 || bus.Out_Dv !== 1'b0 || bus.Out_Data !== '0 ||
                bus.Out_Row !== '0 || bus.Out_Last !== 1'b0 || busy32 !== 1'b0 ||
                bus16.Out_Dv !== 1'b0 || busy16 !== 1'b0) begin
                n_err++;
                $display("FAIL reset_values pass=%0d got rdy=%b dv=%b data=%h row=%0d last=%b busy=%b",
                         pass, bus.In_Rdy, bus.Out_Dv, bus.Out_Data, bus.Out_Row, bus.Out_Last, busy32);
            end
            Rst_n = 1'b1;
            @(negedge Clk);
        end
    endtask

    task automatic test_identity();
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < R; r++) a_m[r][k] = (r == k) ? 8'sd1 : 8'sd0;
            for (int c = 0; c < C; c++) b_m[k][c] = N'(k * 4 + c);
        end
        send_tile(4, 1'b0, 1'b0);
        recv_tile(-1, 0);
        n_cmp++;
        if (cap32_last[3*ACC_W +: ACC_W] !== 32'd15) begin
            n_err++;
            $display("FAIL identity_p33 got=%0d exp=15", cap32_last[3*ACC_W +: ACC_W]);
        end
    endtask

    task automatic test_accumulate();
        send_tile(4, 1'b1, 1'b0);
        recv_tile(-1, 0);
        n_cmp++;
        if (cap32_last[3*ACC_W +: ACC_W] !== 32'd30) begin
            n_err++;
            $display("FAIL accumulate_p33 got=%0d exp=30", cap32_last[3*ACC_W +: ACC_W]);
        end
    endtask

    task automatic test_k1_extreme();
        for (int r = 0; r < R; r++) a_m[r][0] = -8'sd128;
        for (int c = 0; c < C; c++) b_m[0][c] = -8'sd128;
        send_tile(1, 1'b0, 1'b0);
        recv_tile(-1, 0);
        n_cmp++;
        if (cap32_last[0 +: ACC_W] !== 32'd16384) begin
            n_err++;
            $display("FAIL k1_extreme got=%0d exp=16384", cap32_last[0 +: ACC_W]);
        end
    endtask

    task automatic test_gaps();
        fill_random(3);
        send_tile(3, 1'b0, 1'b0);
        recv_tile(-1, 0);
        send_tile(3, 1'b0, 1'b1);
        recv_tile(-1, 0);
    endtask

    task automatic test_backpressure();
        fill_random(5);
        send_tile(5, 1'b0, 1'b0);
        recv_tile(1, 5);
    endtask

    task automatic test_wrap();
        for (int r = 0; r < R; r++) a_m[r][0] = 8'sd127;
        for (int c = 0; c < C; c++) b_m[0][c] = 8'sd127;
        for (int t = 0; t < 3; t++) begin
            send_tile(1, (t != 0), 1'b0);
            recv_tile(-1, 0);
        end
        n_cmp++;
        if ($signed(cap16_row0[15:0]) !== -16'sd17149) begin
            n_err++;
            $display("FAIL wrap16 got=%0d exp=-17149", $signed(cap16_row0[15:0]));
        end
    endtask

    task automatic test_reset_mid_drain();
        fill_random(4);
        send_tile(4, 1'b0, 1'b0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.In_Rdy !== 1'b1 || bus.Out_Dv !== 1'b0 || bus.Out_Data !== '0 ||
            bus.Out_Row !== '0 || bus.Out_Last !== 1'b0 || busy32 !== 1'b0 || busy16 !== 1'b0) begin
            n_err++;
            $display("FAIL mid_drain_reset got rdy=%b dv=%b data=%h busy=%b exp reset values",
                     bus.In_Rdy, bus.Out_Dv, bus.Out_Data, busy32);
        end
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) ref_p[r][c] = 64'sd0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        fill_random(3);
        send_tile(3, 1'b1, 1'b0);
        recv_tile(-1, 0);
    endtask

    task automatic test_random();
        int k_len, srow;
        for (int t = 0; t < 8; t++) begin
            k_len = $urandom_range(1, KMAX);
            fill_random(k_len);
            send_tile(k_len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            srow = ($urandom_range(0, 2) == 0) ? $urandom_range(0, R - 1) : -1;
            recv_tile(srow, $urandom_range(1, 4));
        end
    endtask

    initial begin
        Rst_n       = 1'b0;
        bus.In_Dv   = 1'b0;
        bus.In_Last = 1'b0;
        bus.Acc_En  = 1'b0;
        bus.In_A    = '0;
        bus.In_B    = '0;
        bus.Out_Rdy = 1'b1;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) ref_p[r][c] = 64'sd0;
        test_reset();
        test_identity();
        test_accumulate();
        test_k1_extreme();
        test_gaps();
        test_backpressure();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
